// File: rtl/rr_onehot_arb4.sv
// Four-input round-robin arbiter with sticky pending requests.
// Holds a registered one-hot grant until the consumer acknowledges it.
module rr_onehot_arb4 #(
  parameter logic [1:0] RESET_LAST = 2'd3,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             grant_ack,
  output logic [3:0]       grant,
  output logic             grant_valid,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] gnt_count
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       pending_q, pending_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] gnt_count_q, gnt_count_d;

  logic [3:0]       win_oh;
  logic             win_found;
  logic [1:0]       scan_idx;
  logic [1:0]       grant_idx;
  logic [3:0]       clr;

  // circular search starting just after the last granted index
  always_comb begin
    win_oh    = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!win_found && pending_q[scan_idx]) begin
        win_oh[scan_idx] = 1'b1;
        win_found        = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    unique case (1'b1)
      grant_q[0]: grant_idx = 2'd0;
      grant_q[1]: grant_idx = 2'd1;
      grant_q[2]: grant_idx = 2'd2;
      grant_q[3]: grant_idx = 2'd3;
      default:    grant_idx = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    gnt_count_d = gnt_count_q;
    clr         = '0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_oh;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_ack) begin
          clr         = grant_q;
          last_d      = grant_idx;
          gnt_count_d = gnt_count_q + CNT_W'(1);
          grant_d     = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    // a re-request in the ack cycle keeps the bit pending
    pending_d = (pending_q & ~clr) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      pending_q   <= '0;
      last_q      <= RESET_LAST;
      gnt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      pending_q   <= pending_d;
      last_q      <= last_d;
      gnt_count_q <= gnt_count_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == GRANT);
  assign pending     = pending_q;
  assign gnt_count   = gnt_count_q;

endmodule
